tilelink_broadcast_hub: RTL and testbench
=========================================

TILELINK_BROADCAST_HUB -- requirements
Module: tilelink_broadcast_hub

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; parameters and ports SHALL be as listed below.
REQ-002 Parameters (name, default, meaning):
- NUM_CLIENTS, 2, number of caching clients (>=1).
- ADDR_W, 28, address width.
- DATA_W, 128, beat width; one beat is one cache line.
REQ-003 Ports (name, direction, width, meaning):
- tilelink_clk_i, in, 1, clock.
- tilelink_reset_i, in, 1, asynchronous active-high reset.
- c_a_valid_i / c_a_ready_o, in/out, N, per-client A handshake (N = NUM_CLIENTS).
- c_a_opcode_i / c_a_param_i, in, 3N, per-client A opcode and param.
- c_a_address_i, in, ADDR_W*N, per-client A address.
- c_b_valid_o / c_b_ready_i, out/in, N, per-client B handshake.
- b_param_o, out, 3, shared Probe cap.
- b_address_o, out, ADDR_W, shared Probe address.
- c_c_valid_i / c_c_ready_o, in/out, N, per-client C handshake.
- c_c_opcode_i, in, 3N, per-client C opcode.
- c_c_data_i, in, DATA_W*N, per-client C data.
- c_d_valid_o / c_d_ready_i, out/in, N, per-client D handshake.
- d_opcode_o / d_param_o, out, 3 each, shared D opcode and param.
- d_data_o, out, DATA_W, shared D data.
- c_e_valid_i / c_e_ready_o, in/out, N, per-client GrantAck handshake.
- m_a_valid_o / m_a_ready_i, out/in, 1, memory A handshake.
- m_a_opcode_o, out, 3, memory A opcode.
- m_a_address_o, out, ADDR_W, memory A address.
- m_a_data_o, out, DATA_W, memory A data.
- m_d_valid_i / m_d_ready_o, in/out, 1, memory D handshake.
- m_d_data_i, in, DATA_W, memory D data.

Function
REQ-004 The hub SHALL serialise transactions: one AcquireBlock (opcode 6) in flight at a time.
REQ-005 In IDLE, A arbitration SHALL be round-robin among valid clients; the pointer SHALL advance past the winner on each grant.
REQ-006 c_a_ready_o SHALL be high only for the winner, only in IDLE; on handshake the hub SHALL latch requester, address and param.
REQ-007 The FSM states SHALL be IDLE, PROBE, ACK, WB, WB_RESP, READ, READ_RESP, GRANT and WAIT_E.
REQ-008 A-opcodes other than 6 SHALL be handshaken and answered with D opcode 4 (Grant) and denied semantics (d_param_o=2, toN), skipping PROBE through READ_RESP.
REQ-009 PROBE:
- c_b_valid_o SHALL assert the cycle after A acceptance for every client except the requester.
- Each bit SHALL clear independently on its handshake.
- b_param_o SHALL be 1 (toB) for A-param 0 (NtoB) and 2 (toN) otherwise.
- The FSM SHALL move to ACK when all bits are clear.
REQ-010 With NUM_CLIENTS=1, the FSM SHALL go from IDLE directly to READ.
REQ-011 ACK:
- c_c_ready_o SHALL be high for the lowest-index probed client not yet acknowledged.
- ProbeAck (4) SHALL clear that client's pending bit.
- ProbeAckData (5) SHALL clear the pending bit, latch the data and enter WB.
- The FSM SHALL go to READ when no bits are pending.
REQ-012 WB SHALL issue PutFullData (opcode 0) with the latched address and data; WB_RESP SHALL hold m_d_ready_o=1 and return to ACK on the m_d handshake.
REQ-013 READ SHALL issue Get (opcode 4); READ_RESP SHALL latch m_d_data_i on the handshake and go to GRANT.
REQ-014 GRANT:
- c_d_valid_o SHALL assert only for the requester.
- d_opcode_o SHALL be 5 (GrantData).
- d_param_o SHALL be 0 (toT) for A-param 1/2 and 1 (toB) for 0.
- The FSM SHALL go to WAIT_E on the handshake.
REQ-015 WAIT_E SHALL raise c_e_ready_o for the requester only and return to IDLE on the handshake; other E valids SHALL be ignored.
REQ-016 Every valid output SHALL hold, with stable payload, until its ready is seen.

Reset
REQ-017 Asserting tilelink_reset_i SHALL immediately, including mid-transaction, force:
- IDLE, arbitration pointer 0, pending masks 0.
- All valid and ready outputs 0; all payload outputs 0.
REQ-018 A transaction interrupted by reset SHALL be discarded; no response SHALL be issued for it after reset deasserts.

Configuration
REQ-019 Feature macro TL_BCAST_DIRTY_FWD_EN:
- Defined: after ACK, if any ProbeAckData was received, the FSM SHALL skip READ/READ_RESP and send GrantData carrying the forwarded dirty data (the writeback still occurs).
- Undefined: READ SHALL always be performed.

Verification
REQ-020 N=2, client0 AcquireBlock param 1 at 0x100 -> Probe param 2 on client1 only; ProbeAck; Get 0x100; GrantData param 0 to client0; E accepted; back to IDLE.
REQ-021 Client1 answers ProbeAckData 0xAB.. -> PutFullData 0x100 with 0xAB.. before the Get; with TL_BCAST_DIRTY_FWD_EN, no Get and d_data_o=0xAB...
REQ-022 Clients 0 and 1 both request continuously -> grants alternate 0,1,0,1.
REQ-023 c_b_ready_i held low for 5 cycles -> c_b_valid_o and b_address_o stable for 5 cycles; no C accepted before ACK.
REQ-024 Reset asserted in READ_RESP -> all valids 0 in the same cycle; after release, IDLE and no D issued.
REQ-025 N=1, Acquire param 0 -> no B activity; Get, then GrantData param 1.

Source files
------------

// File: rtl/tilelink_broadcast_hub.sv
// Serialising TileLink broadcast coherence hub: one AcquireBlock at a time, probes all other clients.
// Optional feature macro TL_BCAST_DIRTY_FWD_EN forwards ProbeAckData to the requester instead of re-reading memory.
module tilelink_broadcast_hub #(
    parameter int NUM_CLIENTS = 2,
    parameter int ADDR_W      = 28,
    parameter int DATA_W      = 128
) (
    input  logic                          tilelink_clk_i,
    input  logic                          tilelink_reset_i,
    input  logic [NUM_CLIENTS-1:0]        c_a_valid_i,
    output logic [NUM_CLIENTS-1:0]        c_a_ready_o,
    input  logic [3*NUM_CLIENTS-1:0]      c_a_opcode_i,
    input  logic [3*NUM_CLIENTS-1:0]      c_a_param_i,
    input  logic [ADDR_W*NUM_CLIENTS-1:0] c_a_address_i,
    output logic [NUM_CLIENTS-1:0]        c_b_valid_o,
    input  logic [NUM_CLIENTS-1:0]        c_b_ready_i,
    output logic [2:0]                    b_param_o,
    output logic [ADDR_W-1:0]             b_address_o,
    input  logic [NUM_CLIENTS-1:0]        c_c_valid_i,
    output logic [NUM_CLIENTS-1:0]        c_c_ready_o,
    input  logic [3*NUM_CLIENTS-1:0]      c_c_opcode_i,
    input  logic [DATA_W*NUM_CLIENTS-1:0] c_c_data_i,
    output logic [NUM_CLIENTS-1:0]        c_d_valid_o,
    input  logic [NUM_CLIENTS-1:0]        c_d_ready_i,
    output logic [2:0]                    d_opcode_o,
    output logic [2:0]                    d_param_o,
    output logic [DATA_W-1:0]             d_data_o,
    input  logic [NUM_CLIENTS-1:0]        c_e_valid_i,
    output logic [NUM_CLIENTS-1:0]        c_e_ready_o,
    output logic                          m_a_valid_o,
    input  logic                          m_a_ready_i,
    output logic [2:0]                    m_a_opcode_o,
    output logic [ADDR_W-1:0]             m_a_address_o,
    output logic [DATA_W-1:0]             m_a_data_o,
    input  logic                          m_d_valid_i,
    output logic                          m_d_ready_o,
    input  logic [DATA_W-1:0]             m_d_data_i
);
    localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

    typedef enum logic [3:0] {
        IDLE, PROBE, ACK, WB, WB_RESP, READ, READ_RESP, GRANT, WAIT_E
    } state_t;

    state_t                 state_reg, state_next;
    logic [IDX_W-1:0]       ptr_reg, ptr_next;
    logic [IDX_W-1:0]       req_reg, req_next;
    logic [ADDR_W-1:0]      addr_reg, addr_next;
    logic [2:0]             param_reg, param_next;
    logic                   acq_reg, acq_next;
    logic                   dirty_reg, dirty_next;
    logic [NUM_CLIENTS-1:0] probe_reg, probe_next;
    logic [NUM_CLIENTS-1:0] ack_reg, ack_next;
    logic [DATA_W-1:0]      wb_data_reg, wb_data_next;
    logic [DATA_W-1:0]      grant_data_reg, grant_data_next;

    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    int                     ack_idx;
    logic [NUM_CLIENTS-1:0] win_hot, req_hot, ack_low;

    // Round-robin search starting at the pointer; first valid client wins.
    always_comb begin
        int c;
        c         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_CLIENTS; k++) begin
            c = (int'(ptr_reg) + k) % NUM_CLIENTS;
            if (!win_found && c_a_valid_i[c]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(c);
            end
        end
    end

    always_comb begin
        ack_idx = 0;
        for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
            if (ack_reg[i]) ack_idx = i;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CLIENTS; gi++) begin : g_hot
            assign win_hot[gi] = win_found && (win_idx == IDX_W'(gi));
            assign req_hot[gi] = (req_reg == IDX_W'(gi));
            assign ack_low[gi] = ack_reg[gi] && (ack_idx == gi);
        end
    endgenerate

    // Payloads are gated by state so they read zero whenever their channel is idle.
    always_comb begin
        c_a_ready_o   = '0;
        c_b_valid_o   = '0;
        b_param_o     = 3'd0;
        b_address_o   = '0;
        c_c_ready_o   = '0;
        c_d_valid_o   = '0;
        d_opcode_o    = 3'd0;
        d_param_o     = 3'd0;
        d_data_o      = '0;
        c_e_ready_o   = '0;
        m_a_valid_o   = 1'b0;
        m_a_opcode_o  = 3'd0;
        m_a_address_o = '0;
        m_a_data_o    = '0;
        m_d_ready_o   = 1'b0;
        case (state_reg)
            IDLE:  if (!tilelink_reset_i) c_a_ready_o = win_hot;
            PROBE: begin
                c_b_valid_o = probe_reg;
                b_param_o   = (param_reg == 3'd0) ? 3'd1 : 3'd2;
                b_address_o = addr_reg;
            end
            ACK:   c_c_ready_o = ack_low;
            WB: begin
                m_a_valid_o   = 1'b1;
                m_a_opcode_o  = 3'd0;
                m_a_address_o = addr_reg;
                m_a_data_o    = wb_data_reg;
            end
            READ: begin
                m_a_valid_o   = 1'b1;
                m_a_opcode_o  = 3'd4;
                m_a_address_o = addr_reg;
            end
            WB_RESP, READ_RESP: m_d_ready_o = 1'b1;
            GRANT: begin
                c_d_valid_o = req_hot;
                d_opcode_o  = acq_reg ? 3'd5 : 3'd4;
                d_param_o   = !acq_reg ? 3'd2 : ((param_reg == 3'd0) ? 3'd1 : 3'd0);
                d_data_o    = grant_data_reg;
            end
            WAIT_E: c_e_ready_o = req_hot;
            default: ;
        endcase
    end

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        req_next        = req_reg;
        addr_next       = addr_reg;
        param_next      = param_reg;
        acq_next        = acq_reg;
        dirty_next      = dirty_reg;
        probe_next      = probe_reg;
        ack_next        = ack_reg;
        wb_data_next    = wb_data_reg;
        grant_data_next = grant_data_reg;
        case (state_reg)
            IDLE: if (win_found) begin
                req_next   = win_idx;
                addr_next  = c_a_address_i[int'(win_idx)*ADDR_W +: ADDR_W];
                param_next = c_a_param_i[int'(win_idx)*3 +: 3];
                ptr_next   = (win_idx == IDX_W'(NUM_CLIENTS - 1)) ? '0 : win_idx + 1'b1;
                dirty_next = 1'b0;
                if (c_a_opcode_i[int'(win_idx)*3 +: 3] == 3'd6) begin
                    acq_next = 1'b1;
                    if (NUM_CLIENTS == 1) begin
                        probe_next = '0;
                        ack_next   = '0;
                        state_next = READ;
                    end else begin
                        probe_next = ~win_hot;
                        ack_next   = ~win_hot;
                        state_next = PROBE;
                    end
                end else begin
                    // Non-acquire requests are denied without touching memory.
                    acq_next        = 1'b0;
                    grant_data_next = '0;
                    state_next      = GRANT;
                end
            end
            PROBE: begin
                probe_next = probe_reg & ~c_b_ready_i;
                if (probe_next == '0) state_next = ACK;
            end
            ACK: begin
                if (ack_reg == '0) begin
`ifdef TL_BCAST_DIRTY_FWD_EN
                    if (dirty_reg) begin
                        grant_data_next = wb_data_reg;
                        state_next      = GRANT;
                    end else begin
                        state_next = READ;
                    end
`else
                    state_next = READ;
`endif
                end else if (|(c_c_valid_i & ack_low)) begin
                    ack_next = ack_reg & ~ack_low;
                    if (c_c_opcode_i[ack_idx*3 +: 3] == 3'd5) begin
                        wb_data_next = c_c_data_i[ack_idx*DATA_W +: DATA_W];
                        dirty_next   = 1'b1;
                        state_next   = WB;
                    end
                end
            end
            WB:        if (m_a_ready_i) state_next = WB_RESP;
            WB_RESP:   if (m_d_valid_i) state_next = ACK;
            READ:      if (m_a_ready_i) state_next = READ_RESP;
            READ_RESP: if (m_d_valid_i) begin
                grant_data_next = m_d_data_i;
                state_next      = GRANT;
            end
            GRANT:     if (|(c_d_ready_i & req_hot)) state_next = WAIT_E;
            WAIT_E:    if (|(c_e_valid_i & req_hot)) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_ff @(posedge tilelink_clk_i or posedge tilelink_reset_i) begin
        if (tilelink_reset_i) begin
            state_reg      <= IDLE;
            ptr_reg        <= '0;
            req_reg        <= '0;
            addr_reg       <= '0;
            param_reg      <= 3'd0;
            acq_reg        <= 1'b0;
            dirty_reg      <= 1'b0;
            probe_reg      <= '0;
            ack_reg        <= '0;
            wb_data_reg    <= '0;
            grant_data_reg <= '0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            req_reg        <= req_next;
            addr_reg       <= addr_next;
            param_reg      <= param_next;
            acq_reg        <= acq_next;
            dirty_reg      <= dirty_next;
            probe_reg      <= probe_next;
            ack_reg        <= ack_next;
            wb_data_reg    <= wb_data_next;
            grant_data_reg <= grant_data_next;
        end
    end
endmodule

// File: tb/tb_tilelink_broadcast_hub.sv
// Scoreboard bench for tilelink_broadcast_hub: a 2-client and a 1-client instance; every handshake is checked in order.
// Expectations follow TL_BCAST_DIRTY_FWD_EN when it is defined for the build.
module tb_tilelink_broadcast_hub;
    localparam int N  = 2;
    localparam int AW = 28;
    localparam int DW = 128;
    localparam int K_A = 0, K_B = 1, K_M = 2, K_D = 3, K_E = 4;
    localparam logic [DW-1:0] MEM   = 128'h0123456789ABCDEF_FEDCBA9876543210;
    localparam logic [DW-1:0] DIRTY = {16{8'hAB}};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0] a_valid, a_ready, b_valid, b_ready, c_valid, c_ready, d_valid, d_ready, e_valid, e_ready;
    logic [3*N-1:0] a_opcode, a_param, c_opcode;
    logic [AW*N-1:0] a_addr;
    logic [DW*N-1:0] c_data;
    logic [2:0] b_param, d_opcode, d_param, m_a_opcode;
    logic [AW-1:0] b_addr, m_a_address;
    logic [DW-1:0] d_data, m_a_data, m_d_data;
    logic m_a_valid, m_a_ready, m_d_valid, m_d_ready;

    logic a_valid1, a_ready1, b_valid1, b_ready1, c_valid1, c_ready1, d_valid1, d_ready1, e_valid1, e_ready1;
    logic [2:0] a_opcode1, a_param1, c_opcode1, b_param1, d_opcode1, d_param1, m_a_opcode1;
    logic [AW-1:0] a_addr1, b_addr1, m_a_address1;
    logic [DW-1:0] c_data1, d_data1, m_a_data1;
    logic m_a_valid1, m_a_ready1, m_d_valid1, m_d_ready1;

    tilelink_broadcast_hub #(.NUM_CLIENTS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .tilelink_clk_i(clk), .tilelink_reset_i(rst),
        .c_a_valid_i(a_valid), .c_a_ready_o(a_ready), .c_a_opcode_i(a_opcode), .c_a_param_i(a_param),
        .c_a_address_i(a_addr), .c_b_valid_o(b_valid), .c_b_ready_i(b_ready), .b_param_o(b_param),
        .b_address_o(b_addr), .c_c_valid_i(c_valid), .c_c_ready_o(c_ready), .c_c_opcode_i(c_opcode),
        .c_c_data_i(c_data), .c_d_valid_o(d_valid), .c_d_ready_i(d_ready), .d_opcode_o(d_opcode),
        .d_param_o(d_param), .d_data_o(d_data), .c_e_valid_i(e_valid), .c_e_ready_o(e_ready),
        .m_a_valid_o(m_a_valid), .m_a_ready_i(m_a_ready), .m_a_opcode_o(m_a_opcode),
        .m_a_address_o(m_a_address), .m_a_data_o(m_a_data), .m_d_valid_i(m_d_valid),
        .m_d_ready_o(m_d_ready), .m_d_data_i(m_d_data)
    );

    tilelink_broadcast_hub #(.NUM_CLIENTS(1), .ADDR_W(AW), .DATA_W(DW)) dut1 (
        .tilelink_clk_i(clk), .tilelink_reset_i(rst),
        .c_a_valid_i(a_valid1), .c_a_ready_o(a_ready1), .c_a_opcode_i(a_opcode1), .c_a_param_i(a_param1),
        .c_a_address_i(a_addr1), .c_b_valid_o(b_valid1), .c_b_ready_i(b_ready1), .b_param_o(b_param1),
        .b_address_o(b_addr1), .c_c_valid_i(c_valid1), .c_c_ready_o(c_ready1), .c_c_opcode_i(c_opcode1),
        .c_c_data_i(c_data1), .c_d_valid_o(d_valid1), .c_d_ready_i(d_ready1), .d_opcode_o(d_opcode1),
        .d_param_o(d_param1), .d_data_o(d_data1), .c_e_valid_i(e_valid1), .c_e_ready_o(e_ready1),
        .m_a_valid_o(m_a_valid1), .m_a_ready_i(m_a_ready1), .m_a_opcode_o(m_a_opcode1),
        .m_a_address_o(m_a_address1), .m_a_data_o(m_a_data1), .m_d_valid_i(m_d_valid1),
        .m_d_ready_o(m_d_ready1), .m_d_data_i(m_d_data)
    );

    typedef struct {
        int dut; int kind; int client; int op; int param;
        logic [AW-1:0] addr; logic [DW-1:0] data;
    } evt_t;

    evt_t exp_q[$];
    int vectors = 0;
    int miscompares = 0;

    function automatic evt_t mk(int dv, int kind, int client, int op, int param,
                                logic [AW-1:0] addr, logic [DW-1:0] data);
        evt_t e;
        e.dut = dv; e.kind = kind; e.client = client; e.op = op; e.param = param;
        e.addr = addr; e.data = data;
        return e;
    endfunction

    task automatic push(int dv, int kind, int client, int op, int param,
                        logic [AW-1:0] addr, logic [DW-1:0] data);
        exp_q.push_back(mk(dv, kind, client, op, param, addr, data));
    endtask

    task automatic check(string name, logic [DW-1:0] got, logic [DW-1:0] req);
        vectors++;
        if (got !== req) begin
            miscompares++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    task automatic observe(evt_t g);
        evt_t e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected handshake: dut%0d kind %0d client %0d op %0d param %0d addr %h",
                     g.dut, g.kind, g.client, g.op, g.param, g.addr);
        end else begin
            e = exp_q.pop_front();
            if (g.dut != e.dut || g.kind != e.kind || g.client != e.client || g.op != e.op ||
                g.param != e.param || g.addr !== e.addr || g.data !== e.data) begin
                miscompares++;
                $display("FAIL event: got dut%0d k%0d c%0d op%0d p%0d a=%h d=%h, required dut%0d k%0d c%0d op%0d p%0d a=%h d=%h",
                         g.dut, g.kind, g.client, g.op, g.param, g.addr, g.data,
                         e.dut, e.kind, e.client, e.op, e.param, e.addr, e.data);
            end else begin
                $display("txn dut%0d kind %0d client %0d op %0d param %0d addr %h ok",
                         g.dut, g.kind, g.client, g.op, g.param, g.addr);
            end
        end
    endtask

    // Monitor: every handshake seen on the clock's falling edge is matched against the queue.
    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < N; i++) begin
                if (a_valid[i] && a_ready[i]) observe(mk(0, K_A, i, 0, 0, '0, '0));
                if (b_valid[i] && b_ready[i]) observe(mk(0, K_B, i, 0, int'(b_param), b_addr, '0));
                if (d_valid[i] && d_ready[i]) observe(mk(0, K_D, i, int'(d_opcode), int'(d_param), '0, d_data));
                if (e_valid[i] && e_ready[i]) observe(mk(0, K_E, i, 0, 0, '0, '0));
            end
            if (m_a_valid && m_a_ready) observe(mk(0, K_M, 0, int'(m_a_opcode), 0, m_a_address, m_a_data));
            if (a_valid1 && a_ready1) observe(mk(1, K_A, 0, 0, 0, '0, '0));
            if (b_valid1 && b_ready1) observe(mk(1, K_B, 0, 0, int'(b_param1), b_addr1, '0));
            if (d_valid1 && d_ready1) observe(mk(1, K_D, 0, int'(d_opcode1), int'(d_param1), '0, d_data1));
            if (e_valid1 && e_ready1) observe(mk(1, K_E, 0, 0, 0, '0, '0));
            if (m_a_valid1 && m_a_ready1) observe(mk(1, K_M, 0, int'(m_a_opcode1), 0, m_a_address1, m_a_data1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_a(int cl, int op, int par, logic [AW-1:0] addr);
        a_opcode[cl*3 +: 3] = 3'(op);
        a_param[cl*3 +: 3]  = 3'(par);
        a_addr[cl*AW +: AW] = addr;
        a_valid[cl]         = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (a_ready[cl]) begin
                step();
                a_valid[cl] = 1'b0;
                return;
            end
        end
        a_valid[cl] = 1'b0;
        check("a_accept_timeout", 1'b0, 1'b1);
    endtask

    task automatic drain(string name);
        for (int t = 0; t < 300 && exp_q.size() != 0; t++) step();
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_quiet(string tag);
        check({tag, "_a_ready"}, a_ready, 0);
        check({tag, "_b_valid"}, b_valid, 0);
        check({tag, "_c_ready"}, c_ready, 0);
        check({tag, "_d_valid"}, d_valid, 0);
        check({tag, "_e_ready"}, e_ready, 0);
        check({tag, "_m_a_valid"}, m_a_valid, 0);
        check({tag, "_m_d_ready"}, m_d_ready, 0);
        check({tag, "_b_addr"}, b_addr, 0);
        check({tag, "_m_a_addr"}, m_a_address, 0);
        check({tag, "_d_data"}, d_data, 0);
    endtask

    initial begin
        a_valid = '0; a_opcode = '0; a_param = '0; a_addr = '0;
        b_ready = '1; c_valid = '1; c_opcode = {3'd4, 3'd4}; c_data = {DIRTY, DIRTY};
        d_ready = '1; e_valid = '1; m_a_ready = 1'b1; m_d_valid = 1'b1; m_d_data = MEM;
        a_valid1 = 1'b0; a_opcode1 = 3'd0; a_param1 = 3'd0; a_addr1 = '0;
        b_ready1 = 1'b1; c_valid1 = 1'b1; c_opcode1 = 3'd4; c_data1 = DIRTY;
        d_ready1 = 1'b1; e_valid1 = 1'b1; m_a_ready1 = 1'b1; m_d_valid1 = 1'b1;

        // Reset state, with requests pending to show A ready is held off.
        a_valid = '1;
        #12;
        check_quiet("reset");
        a_valid = '0;
        step();
        rst = 1'b0;
        step();

        // Clean AcquireBlock from client 0, client 1 answers ProbeAck.
        push(0, K_A, 0, 0, 0, '0, '0);
        push(0, K_B, 1, 0, 2, 28'h100, '0);
        push(0, K_M, 0, 4, 0, 28'h100, '0);
        push(0, K_D, 0, 5, 0, '0, MEM);
        push(0, K_E, 0, 0, 0, '0, '0);
        send_a(0, 6, 1, 28'h100);
        drain("drain_clean");

        // Dirty ProbeAckData from client 1 forces a writeback first.
        c_opcode[5:3] = 3'd5;
        push(0, K_A, 0, 0, 0, '0, '0);
        push(0, K_B, 1, 0, 1, 28'h200, '0);
        push(0, K_M, 0, 0, 0, 28'h200, DIRTY);
`ifdef TL_BCAST_DIRTY_FWD_EN
        push(0, K_D, 0, 5, 1, '0, DIRTY);
`else
        push(0, K_M, 0, 4, 0, 28'h200, '0);
        push(0, K_D, 0, 5, 1, '0, MEM);
`endif
        push(0, K_E, 0, 0, 0, '0, '0);
        send_a(0, 6, 0, 28'h200);
        drain("drain_dirty");
        c_opcode[5:3] = 3'd4;

        // Both clients request continuously: grants alternate from a fresh pointer.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            int w;
            int o;
            logic [AW-1:0] ad;
            w  = k % 2;
            o  = 1 - w;
            ad = (w == 0) ? 28'h300 : 28'h400;
            push(0, K_A, w, 0, 0, '0, '0);
            push(0, K_B, o, 0, 2, ad, '0);
            push(0, K_M, 0, 4, 0, ad, '0);
            push(0, K_D, w, 5, 0, '0, MEM);
            push(0, K_E, w, 0, 0, '0, '0);
        end
        a_opcode = {3'd6, 3'd6}; a_param = {3'd1, 3'd1}; a_addr = {28'h400, 28'h300};
        a_valid = '1;
        begin
            int cnt;
            cnt = 0;
            for (int t = 0; t < 400 && cnt < 4; t++) begin
                @(negedge clk);
                if (|(a_valid & a_ready)) cnt++;
            end
            step();
            a_valid = '0;
            check("rr_grant_count", cnt, 4);
        end
        drain("drain_rr");

        // Probe back-pressure: B must hold steady and C must stay closed.
        b_ready = '0;
        push(0, K_A, 0, 0, 0, '0, '0);
        push(0, K_B, 1, 0, 2, 28'h500, '0);
        push(0, K_M, 0, 4, 0, 28'h500, '0);
        push(0, K_D, 0, 5, 0, '0, MEM);
        push(0, K_E, 0, 0, 0, '0, '0);
        send_a(0, 6, 2, 28'h500);
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            check("hold_b_valid", b_valid, 2'b10);
            check("hold_b_addr", b_addr, 28'h500);
            check("hold_b_param", b_param, 3'd2);
            check("hold_c_ready", c_ready, 2'b00);
        end
        step();
        b_ready = '1;
        drain("drain_hold");

        // Reset while waiting for memory data: transaction must vanish.
        m_d_valid = 1'b0;
        push(0, K_A, 1, 0, 0, '0, '0);
        push(0, K_B, 0, 0, 2, 28'h600, '0);
        push(0, K_M, 0, 4, 0, 28'h600, '0);
        send_a(1, 6, 2, 28'h600);
        begin
            bit seen;
            seen = 1'b0;
            for (int t = 0; t < 100 && !seen; t++) begin
                @(negedge clk);
                if (m_d_ready) seen = 1'b1;
            end
            check("reach_read_resp", seen, 1'b1);
        end
        #2;
        rst = 1'b1;
        #1;
        check_quiet("midreset");
        step();
        step();
        rst = 1'b0;
        m_d_valid = 1'b1;
        for (int t = 0; t < 20; t++) step();
        check("post_reset_queue", exp_q.size(), 0);

        // Non-acquire request is denied directly.
        push(0, K_A, 1, 0, 0, '0, '0);
        push(0, K_D, 1, 4, 2, '0, '0);
        push(0, K_E, 1, 0, 0, '0, '0);
        send_a(1, 4, 0, 28'h700);
        drain("drain_denied");

        // Single-client hub: straight to READ, GrantData toB.
        push(1, K_A, 0, 0, 0, '0, '0);
        push(1, K_M, 0, 4, 0, 28'h800, '0);
        push(1, K_D, 0, 5, 1, '0, MEM);
        push(1, K_E, 0, 0, 0, '0, '0);
        a_opcode1 = 3'd6; a_param1 = 3'd0; a_addr1 = 28'h800; a_valid1 = 1'b1;
        begin
            bit acc;
            acc = 1'b0;
            for (int t = 0; t < 100 && !acc; t++) begin
                @(negedge clk);
                if (a_ready1) acc = 1'b1;
            end
            step();
            a_valid1 = 1'b0;
            check("n1_accept", acc, 1'b1);
        end
        drain("drain_n1");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
